reset_req_gen: RTL and testbench

RESET_REQ_GEN -- requirements
Module: reset_req_gen

---
 rtl/reset_req_gen.sv | 161 ++++++++++++++++
 tb/tb_reset_req_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reset_req_gen.sv
// reset_req_gen: power-on, pushbutton and software reset sequencer.
// Produces a registered active-low reset (rst_out_n) for downstream
// synchronisers, a busy flag, and a sticky record of the last reset cause.
module reset_req_gen #(
    parameter int POR_CYCLES      = 1024,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 1000
) (
    input  logic       clk,
    input  logic       rst_async_n,
    input  logic       button_n,
    input  logic       sw_rst_req,
    output logic       rst_out_n,
    output logic       rst_busy,
    output logic [1:0] rst_cause
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MAIN_MAX = (POR_CYCLES > HOLD_CYCLES) ? POR_CYCLES : HOLD_CYCLES;
    localparam int CNT_W    = $clog2(MAIN_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_SW     = 2'b10;

    typedef enum logic [1:0] {
        S_POR      = 2'd0,
        S_RUN      = 2'd1,
        S_HOLD     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_e;

    // Button synchroniser and debouncer state
    logic            btn_meta_q, btn_meta_d;
    logic            btn_sync_q, btn_sync_d;
    logic            btn_db_q,   btn_db_d;
    logic [DB_W-1:0] db_cnt_q,   db_cnt_d;
    logic            press;

    // Sequencer state
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       rst_cause_q, rst_cause_d;
    logic             rst_out_n_q, rst_out_n_d;
    logic             rst_busy_q,  rst_busy_d;

    // Synchronise the button, then accept a new level only after it has been
    // stable for DEBOUNCE_CYCLES consecutive synchronised samples.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        btn_meta_d = button_n;
        btn_sync_d = btn_meta_q;
        btn_db_d   = btn_db_q;
        db_cnt_d   = db_cnt_q;
        if (btn_sync_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_sync_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // A press is the debounced level falling, acted on in the same cycle.
    assign press = btn_db_q & ~btn_db_d;

    // Next-state, counter and cause logic; outputs are decoded from the
    // next state so they can be registered without adding latency.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_cause_d = rst_cause_q;
        unique case (state_q)
            S_POR: begin
                if (cnt_q == POR_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // Button wins a tie with a software request.
                if (press) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    rst_cause_d = CAUSE_BUTTON;
                end else if (sw_rst_req) begin
                    state_d     = S_HOLD;
                    cnt_d       = '0;
                    rst_cause_d = CAUSE_SW;
                end
            end
            S_HOLD: begin
                // Requests are ignored here, so the pulse is never stretched.
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_REL: begin
                if (btn_db_q && !sw_rst_req) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_POR;
                cnt_d   = '0;
            end
        endcase
        rst_out_n_d = (state_d == S_RUN);
        rst_busy_d  = (state_d != S_RUN);
    end

    // Debouncer registers; reset to the released level.
    always_ff @(posedge clk or negedge rst_async_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from values sampled before the edge.
        if (!rst_async_n) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
            btn_db_q   <= 1'b1;
            db_cnt_q   <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_db_q   <= btn_db_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Sequencer registers; reset forces rst_out_n low with no path to 1.
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q     <= S_POR;
            cnt_q       <= '0;
            rst_cause_q <= CAUSE_POR;
            rst_out_n_q <= 1'b0;
            rst_busy_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_cause_q <= rst_cause_d;
            rst_out_n_q <= rst_out_n_d;
            rst_busy_q  <= rst_busy_d;
        end
    end

    assign rst_out_n = rst_out_n_q;
    assign rst_busy  = rst_busy_q;
    assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_reset_req_gen.sv
// Self-checking bench for reset_req_gen with small parameters.
// Each step pushes the expected {rst_out_n, rst_busy, rst_cause} onto a
// scoreboard queue, and the value is popped and compared after the edge.
module tb_reset_req_gen;

    localparam int POR  = 16;
    localparam int DB   = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_async_n = 1'b0;
    logic       button_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       rst_out_n;
    logic       rst_busy;
    logic [1:0] rst_cause;

    typedef struct {
        string      tag;
        logic [3:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    reset_req_gen #(
        .POR_CYCLES     (POR),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .button_n   (button_n),
        .sw_rst_req (sw_rst_req),
        .rst_out_n  (rst_out_n),
        .rst_busy   (rst_busy),
        .rst_cause  (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic o, input logic b, input logic [1:0] c);
        exp_t e;
        e.tag = tag;
        e.v   = {o, b, c};
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, {28'd0, rst_out_n, rst_busy, rst_cause}, {28'd0, e.v});
        end
    endtask

    // One clock: expectation queued before the edge, compared 1 ns after it.
    task automatic step(input string tag, input logic o, input logic b, input logic [1:0] c);
        push(tag, o, b, c);
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    // Immediate comparison with no clock edge in between.
    task automatic check_now(input string tag, input logic o, input logic b, input logic [1:0] c);
        push(tag, o, b, c);
        pop_cmp();
    endtask

    // Bounded wait for rst_out_n to reach a level; expiry counts as a miscompare.
    task automatic wait_out(input string tag, input logic lvl, input int max_edges);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_edges; i++) begin
            @(posedge clk);
            #1;
            if (rst_out_n === lvl) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic por_sequence(input string tag);
        for (int i = 0; i < POR - 1; i++) step({tag, "_low"}, 1'b0, 1'b1, 2'b00);
        step({tag, "_rise"}, 1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        // Power-up: outputs held in reset, then 15 low edges and a rise on 16.
        repeat (3) @(posedge clk);
        #1;
        check_now("rst_hold", 1'b0, 1'b1, 2'b00);
        rst_async_n = 1'b1;
        por_sequence("por");
        repeat (3) step("run_idle", 1'b1, 1'b0, 2'b00);

        // Software pulse: 8 cycles in hold plus one in wait-release.
        sw_rst_req = 1'b1;
        step("sw_fall", 1'b0, 1'b1, 2'b10);
        sw_rst_req = 1'b0;
        for (int i = 0; i < HOLD; i++) step("sw_low", 1'b0, 1'b1, 2'b10);
        step("sw_rise", 1'b1, 1'b0, 2'b10);
        repeat (2) step("sw_idle", 1'b1, 1'b0, 2'b10);

        // Simultaneous: the debounced press lands on the 6th edge after the
        // button goes low (2 sync flops, then 4 stable samples); sw_rst_req
        // is raised for that same edge. Button wins; a later request inside
        // the hold window does not lengthen the pulse.
        button_n = 1'b0;
        for (int i = 0; i < DB + 1; i++) step("sim_pre", 1'b1, 1'b0, 2'b10);
        sw_rst_req = 1'b1;
        step("sim_fall", 1'b0, 1'b1, 2'b01);
        sw_rst_req = 1'b0;
        button_n   = 1'b1;
        repeat (2) step("sim_low", 1'b0, 1'b1, 2'b01);
        sw_rst_req = 1'b1;
        step("sim_low_req", 1'b0, 1'b1, 2'b01);
        sw_rst_req = 1'b0;
        repeat (5) step("sim_low", 1'b0, 1'b1, 2'b01);
        step("sim_rise", 1'b1, 1'b0, 2'b01);
        repeat (2) step("sim_idle", 1'b1, 1'b0, 2'b01);

        // Held request: low for the whole 30 cycles, rising once it drops.
        sw_rst_req = 1'b1;
        repeat (30) step("held_low", 1'b0, 1'b1, 2'b10);
        sw_rst_req = 1'b0;
        step("held_rise", 1'b1, 1'b0, 2'b10);
        repeat (2) step("held_idle", 1'b1, 1'b0, 2'b10);

        // Bouncy press: 2-cycle runs never satisfy the debouncer.
        for (int i = 0; i < 20; i++) begin
            button_n = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
            step("bounce_run", 1'b1, 1'b0, 2'b10);
        end
        button_n = 1'b0;
        wait_out("press_fall", 1'b0, 2 + DB + 2);
        check_now("press_cause", 1'b0, 1'b1, 2'b01);
        repeat (20) step("press_held", 1'b0, 1'b1, 2'b01);
        button_n = 1'b1;
        repeat (DB + 1) step("rel_pending", 1'b0, 1'b1, 2'b01);
        wait_out("rel_rise", 1'b1, 4);
        check_now("rel_cause", 1'b1, 1'b0, 2'b01);
        repeat (4) step("post_rel", 1'b1, 1'b0, 2'b01);

        // Reset mid-hold: immediate abort, then a full POR with the button
        // held low throughout, whose press must be ignored.
        sw_rst_req = 1'b1;
        step("mid_fall", 1'b0, 1'b1, 2'b10);
        sw_rst_req = 1'b0;
        repeat (3) step("mid_low", 1'b0, 1'b1, 2'b10);
        rst_async_n = 1'b0;
        button_n    = 1'b0;
        #1;
        check_now("mid_rst", 1'b0, 1'b1, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check_now("mid_rst_hold", 1'b0, 1'b1, 2'b00);
        rst_async_n = 1'b1;
        por_sequence("por2");
        repeat (10) step("btn_held_run", 1'b1, 1'b0, 2'b00);
        button_n = 1'b1;
        repeat (10) step("btn_rel_run", 1'b1, 1'b0, 2'b00);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
